bus_flit_serializer: RTL and testbench



---
 rtl/bus_flit_serializer.sv | 71 +++++++
 tb/tb_bus_flit_serializer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_flit_serializer.sv
// bus_flit_serializer: drains agent FIFO flits and shifts them out LSB-first with an optional odd parity bit
module bus_flit_serializer #(
    parameter int flit_size = 32,
    parameter int parity_en = 1,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pndng,
    input  logic [flit_size-1:0] data_out,
    output logic                 pop,
    output logic                 ser_data,
    output logic                 ser_valid,
    input  logic                 ser_rdy,
    output logic                 ser_last,
    output logic                 busy,
    output logic [cnt_width-1:0] flits_sent
);
    localparam int bw = (flit_size > 1) ? $clog2(flit_size) : 1;
    localparam logic [bw-1:0] last_bit = bw'(flit_size - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t               state, state_nxt;
    logic [flit_size-1:0] shreg;
    logic [bw-1:0]        bitcnt;
    logic                 par;
    logic                 frame_done;
    logic                 data_end;

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // a load always starts a new frame; otherwise advance only on accepted bits
    always_comb begin
        state_nxt = pop ? DATA : frame_done ? IDLE : data_end ? PAR : state;
    end

    // serial outputs, handshake qualifiers and the pop strobe
    always_comb begin
        busy       = state != IDLE;
        ser_valid  = busy;
        ser_data   = (state == DATA) ? shreg[0] : (state == PAR) ? par : 1'b0;
        ser_last   = (state == PAR) || (state == DATA && parity_en == 0 && bitcnt == last_bit);
        frame_done = ser_valid && ser_rdy && ser_last;
        data_end   = state == DATA && ser_rdy && bitcnt == last_bit;
        pop        = !rst && pndng && (state == IDLE || frame_done);
    end

    // shift datapath and completed-frame counter; everything holds while the far end stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            flits_sent <= '0;
        end else begin
            if (pop) begin
                shreg  <= data_out;
                bitcnt <= '0;
                par    <= ~^data_out;
            end else if (state == DATA && ser_rdy) begin
                shreg  <= shreg >> 1;
                bitcnt <= bitcnt + bw'(1);
            end
            if (frame_done) flits_sent <= flits_sent + cnt_width'(1);
        end
    end
endmodule

// File: tb/tb_bus_flit_serializer.sv
// tb_bus_flit_serializer: randomized and directed checks of the flit serializer against a frame-level model
module tb_bus_flit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pndng = 1'b0;
    logic       ser_rdy = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       pop, ser_data, ser_valid, ser_last, busy;
    logic [1:0] flits_sent;

    logic        pndng_b = 1'b0;
    logic        rdy_b = 1'b1;
    logic [7:0]  data_b = 8'h00;
    logic        pop_b, sd_b, sv_b, sl_b, busy_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int fails = 0;

    logic [7:0]   src_q[$];
    logic [7:0]   exp_flits[$];
    logic [127:0] exp_vec, exp_last, acc_vec, acc_last;
    int           exp_n, acc_n;
    int           cyc, pops, vcycles, first_v, last_v, hold_cnt, withdraw_err;
    int           pop_log[$];
    logic [1:0]   cnt_log[$];
    bit           rand_mode;
    int           stall_lo, stall_hi;
    logic         p_valid;
    logic         s_pop, s_valid, s_data, s_last, s_busy;
    logic [1:0]   s_cnt;

    always #5 clk = ~clk;

    bus_flit_serializer #(.flit_size(8), .parity_en(1), .cnt_width(2)) dut (
        .clk(clk), .rst(rst), .pndng(pndng), .data_out(data_out), .pop(pop),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_rdy(ser_rdy), .ser_last(ser_last),
        .busy(busy), .flits_sent(flits_sent)
    );

    bus_flit_serializer #(.flit_size(8), .parity_en(0), .cnt_width(16)) dut_np (
        .clk(clk), .rst(rst), .pndng(pndng_b), .data_out(data_b), .pop(pop_b),
        .ser_data(sd_b), .ser_valid(sv_b), .ser_rdy(rdy_b), .ser_last(sl_b),
        .busy(busy_b), .flits_sent(cnt_b)
    );

    // expected serial stream: each flit LSB first, then odd parity when enabled
    task automatic build_exp(input bit pe);
        exp_vec = '0;
        exp_last = '0;
        exp_n = 0;
        foreach (exp_flits[k]) begin
            for (int i = 0; i < 8; i++) begin
                exp_vec[exp_n] = exp_flits[k][i];
                exp_last[exp_n] = !pe && i == 7;
                exp_n++;
            end
            if (pe) begin
                exp_vec[exp_n] = ~^exp_flits[k];
                exp_last[exp_n] = 1'b1;
                exp_n++;
            end
        end
    endtask

    task automatic drive();
        logic gap;
        gap = rand_mode && ($urandom_range(0, 3) == 0);
        pndng = (src_q.size() != 0) && !gap;
        data_out = pndng ? src_q[0] : 8'($urandom);
        ser_rdy = rand_mode ? ($urandom_range(0, 2) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic clear_rec();
        cyc = 0; pops = 0; vcycles = 0; first_v = -1; last_v = -1; hold_cnt = 0; withdraw_err = 0;
        acc_n = 0; acc_vec = '0; acc_last = '0; p_valid = 1'b0;
        pop_log.delete(); cnt_log.delete(); exp_flits.delete();
        rand_mode = 0; stall_lo = 1000; stall_hi = -1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        src_q.delete();
        clear_rec();
        drive();
        pndng_b = 1'b0;
        rdy_b = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // one cycle: observe at the falling edge, then let the agent FIFO react to a pop after the rising edge
    task automatic step();
        logic done;
        @(negedge clk);
        s_pop = pop; s_valid = ser_valid; s_data = ser_data; s_last = ser_last; s_busy = busy; s_cnt = flits_sent;
        done = ser_valid && ser_rdy && ser_last;
        if (pop) begin
            pops++;
            pop_log.push_back(cyc);
        end
        if (ser_valid) begin
            vcycles++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (ser_valid && !ser_rdy && ser_data) hold_cnt++;
        if (p_valid && !ser_valid) withdraw_err++;
        p_valid = ser_valid && !done && !rst;
        if (ser_valid && ser_rdy) begin
            acc_vec[acc_n] = ser_data;
            acc_last[acc_n] = ser_last;
            acc_n++;
        end
        @(posedge clk);
        #1;
        if (s_pop) void'(src_q.pop_front());
        if (done) cnt_log.push_back(flits_sent);
        cyc++;
        drive();
    endtask

    task automatic run_idle(input string nm);
        int n;
        n = 0;
        while ((src_q.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        checks++; if (n >= 400) begin fails++; $display("FAIL %s_timeout: got %0d cycles expected <400", nm, n); end
    endtask

    task automatic check_stream(input string nm, input bit pe);
        build_exp(pe);
        checks++; if (acc_n !== exp_n) begin fails++; $display("FAIL %s_len: got %0d expected %0d", nm, acc_n, exp_n); end
        checks++; if (acc_vec !== exp_vec) begin fails++; $display("FAIL %s_bits: got %h expected %h", nm, acc_vec, exp_vec); end
        checks++; if (acc_last !== exp_last) begin fails++; $display("FAIL %s_last: got %h expected %h", nm, acc_last, exp_last); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_rec();
        src_q.push_back(8'h5A);
        drive();
        step();
        checks++; if (s_pop !== 1'b0) begin fails++; $display("FAIL reset_pop: got %b expected 0", s_pop); end
        checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
        checks++; if (s_data !== 1'b0) begin fails++; $display("FAIL reset_data: got %b expected 0", s_data); end
        checks++; if (s_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", s_last); end
        checks++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
        step();
        checks++; if (s_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", s_cnt); end
        checks++; if (cnt_b !== 16'd0) begin fails++; $display("FAIL reset_cnt_b: got %0d expected 0", cnt_b); end
        checks++; if (sv_b !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_b: got valid=%b busy=%b expected 0 0", sv_b, busy_b); end
        src_q.delete();
        drive();
        rst = 1'b0;
    endtask

    task automatic test_single();
        reset_dut();
        src_q.push_back(8'hA5);
        exp_flits.push_back(8'hA5);
        drive();
        step();
        checks++; if (s_pop !== 1'b1 || s_valid !== 1'b0) begin fails++; $display("FAIL single_latency: got pop=%b valid=%b expected 1 0", s_pop, s_valid); end
        run_idle("single");
        check_stream("single", 1'b1);
        checks++; if (pops !== 1) begin fails++; $display("FAIL single_pops: got %0d expected 1", pops); end
        checks++; if (vcycles !== 9 || first_v !== 1) begin fails++; $display("FAIL single_timing: got %0d valid from %0d expected 9 from 1", vcycles, first_v); end
        checks++; if (flits_sent !== 2'd1 || busy !== 1'b0) begin fails++; $display("FAIL single_done: got cnt=%0d busy=%b expected 1 0", flits_sent, busy); end
    endtask

    task automatic test_back_to_back();
        int second;
        reset_dut();
        src_q.push_back(8'h07); src_q.push_back(8'hFF);
        exp_flits.push_back(8'h07); exp_flits.push_back(8'hFF);
        drive();
        run_idle("b2b");
        check_stream("b2b", 1'b1);
        second = (pop_log.size() > 1) ? pop_log[1] : -1;
        checks++; if (pops !== 2 || second !== 9) begin fails++; $display("FAIL b2b_pop: got %0d pops second at %0d expected 2 at 9", pops, second); end
        checks++; if (vcycles !== 18 || last_v - first_v !== 17) begin fails++; $display("FAIL b2b_gap: got %0d valid over %0d expected 18 over 17", vcycles, last_v - first_v); end
        checks++; if (flits_sent !== 2'd2) begin fails++; $display("FAIL b2b_cnt: got %0d expected 2", flits_sent); end
    endtask

    task automatic test_stall();
        reset_dut();
        stall_lo = 3;
        stall_hi = 6;
        src_q.push_back(8'hA5);
        exp_flits.push_back(8'hA5);
        drive();
        run_idle("stall");
        check_stream("stall", 1'b1);
        checks++; if (hold_cnt !== 4) begin fails++; $display("FAIL stall_hold: got %0d expected 4", hold_cnt); end
        checks++; if (vcycles !== 13 || last_v !== 13) begin fails++; $display("FAIL stall_timing: got %0d valid ending %0d expected 13 ending 13", vcycles, last_v); end
        checks++; if (flits_sent !== 2'd1) begin fails++; $display("FAIL stall_cnt: got %0d expected 1", flits_sent); end
    endtask

    task automatic test_no_parity();
        logic [7:0] bv, bl;
        int vn, pn;
        logic tail_valid;
        reset_dut();
        bv = '0; bl = '0; vn = 0; pn = 0;
        pndng_b = 1'b1;
        data_b = 8'h3C;
        @(negedge clk);
        checks++; if (pop_b !== 1'b1 || sv_b !== 1'b0) begin fails++; $display("FAIL nopar_load: got pop=%b valid=%b expected 1 0", pop_b, sv_b); end
        @(posedge clk);
        #1;
        pndng_b = 1'b0;
        data_b = 8'($urandom);
        tail_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (pop_b) pn++;
            if (i < 8) begin
                bv[i] = sd_b;
                bl[i] = sl_b;
                if (sv_b) vn++;
            end else begin
                tail_valid = sv_b;
            end
            @(posedge clk);
            #1;
        end
        exp_flits.push_back(8'h3C);
        build_exp(1'b0);
        checks++; if (bv !== exp_vec[7:0]) begin fails++; $display("FAIL nopar_bits: got %h expected %h", bv, exp_vec[7:0]); end
        checks++; if (bl !== exp_last[7:0]) begin fails++; $display("FAIL nopar_last: got %h expected %h", bl, exp_last[7:0]); end
        checks++; if (vn !== 8 || tail_valid !== 1'b0 || pn !== 0) begin fails++; $display("FAIL nopar_len: got %0d valid tail=%b pops=%0d expected 8 0 0", vn, tail_valid, pn); end
        checks++; if (cnt_b !== 16'd1 || busy_b !== 1'b0) begin fails++; $display("FAIL nopar_cnt: got cnt=%0d busy=%b expected 1 0", cnt_b, busy_b); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        src_q.push_back(8'hA5); src_q.push_back(8'h3C);
        drive();
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++; if (s_pop !== 1'b0) begin fails++; $display("FAIL rstmid_pop: got %b expected 0", s_pop); end
        rst = 1'b0;
        clear_rec();
        drive();
        step();
        checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got valid=%b busy=%b expected 0 0", s_valid, s_busy); end
        checks++; if (s_cnt !== 2'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d expected 0", s_cnt); end
        checks++; if (s_pop !== 1'b1) begin fails++; $display("FAIL rstmid_repop: got %b expected 1", s_pop); end
        exp_flits.push_back(8'h3C);
        run_idle("rstmid");
        check_stream("rstmid", 1'b1);
        checks++; if (pops !== 1 || flits_sent !== 2'd1) begin fails++; $display("FAIL rstmid_after: got pops=%0d cnt=%0d expected 1 1", pops, flits_sent); end
    endtask

    task automatic test_wrap();
        logic [9:0] gw, ew;
        logic [7:0] f;
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            f = 8'($urandom);
            src_q.push_back(f);
            exp_flits.push_back(f);
        end
        drive();
        run_idle("wrap");
        check_stream("wrap", 1'b1);
        for (int k = 0; k < 5; k++) begin
            gw[2*k +: 2] = (k < cnt_log.size()) ? cnt_log[k] : 2'bxx;
            ew[2*k +: 2] = 2'(k + 1);
        end
        checks++; if (gw !== ew || cnt_log.size() !== 5) begin fails++; $display("FAIL wrap_seq: got %h (%0d entries) expected %h (5)", gw, cnt_log.size(), ew); end
    endtask

    task automatic test_random();
        logic [7:0] f;
        int n;
        for (int it = 0; it < 4; it++) begin
            reset_dut();
            rand_mode = 1;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                f = 8'($urandom);
                src_q.push_back(f);
                exp_flits.push_back(f);
            end
            drive();
            run_idle("random");
            check_stream("random", 1'b1);
            checks++; if (pops !== n) begin fails++; $display("FAIL random_pops: got %0d expected %0d", pops, n); end
            checks++; if (flits_sent !== 2'(n)) begin fails++; $display("FAIL random_cnt: got %0d expected %0d", flits_sent, n % 4); end
            checks++; if (withdraw_err !== 0) begin fails++; $display("FAIL random_withdraw: got %0d expected 0", withdraw_err); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_no_parity();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
